// File: rtl/uart_pkg.sv
// Shared constants and arbiter state encoding for the uartTx front-end arbiter.
package uart_pkg;

   localparam int unsigned BYTE_W       = 8;
   localparam int unsigned NREQ_DEF     = 4;
   localparam int unsigned WDOG_CYC_DEF = 8;

   typedef enum logic [1:0] {
      ARB_IDLE      = 2'd0,
      ARB_LAUNCH    = 2'd1,
      ARB_WAIT_BUSY = 2'd2,
      ARB_WAIT_DONE = 2'd3
   } arb_state_e;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin search: first set request after ptr_i, wrapping modulo NREQ.
module uart_rr_pick
   import uart_pkg::*;
#(
   parameter int unsigned NREQ = NREQ_DEF,
   parameter int unsigned IDW  = 2
) (
   input  logic [NREQ-1:0] req_i,
   input  logic [IDW-1:0]  ptr_i,
   output logic            valid_o,
   output logic [IDW-1:0]  win_o
);

   logic [IDW-1:0] cand;

   // Walk offsets from farthest to nearest so the nearest hit is written last.
   always_comb begin
      valid_o = 1'b0;
      win_o   = '0;
      cand    = '0;
      for (int unsigned off = NREQ; off >= 1; off--) begin
         cand = IDW'((32'(ptr_i) + off) % NREQ);
         if (req_i[cand]) begin
            valid_o = 1'b1;
            win_o   = cand;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one uartTx between NREQ requesters.
// Optional TX_BUSY watchdog enabled by defining UART_ARB_WDOG_EN.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int unsigned NREQ     = NREQ_DEF,
   parameter int unsigned IDW      = 2,
   parameter int unsigned WDOG_CYC = WDOG_CYC_DEF
) (
   input  logic                     CLK,
   input  logic                     RST_N,
   input  logic [NREQ-1:0]          REQ,
   input  logic [NREQ*BYTE_W-1:0]   DATA_IN,
   output logic [NREQ-1:0]          ACK,
   output logic [IDW-1:0]           CUR_ID,
   output logic                     ARB_BUSY,
   output logic [BYTE_W-1:0]        TX_DIN,
   output logic                     TX_WR_EN,
   input  logic                     TX_BUSY,
   output logic                     ERR
);

   if (NREQ < 2 || NREQ > 8 || IDW < $clog2(NREQ) || WDOG_CYC < 1) begin : g_cfg_bad
      $error("uart_tx_arbiter: unsupported parameter set");
   end

   arb_state_e          state_q, state_d;
   logic [IDW-1:0]      ptr_q, ptr_d;
   logic [IDW-1:0]      cur_id_q, cur_id_d;
   logic [BYTE_W-1:0]   tx_din_q, tx_din_d;
   logic                wr_en_q, wr_en_d;
   logic [NREQ-1:0]     ack_q, ack_d;

   logic                pick_valid;
   logic [IDW-1:0]      pick_id;
   logic [BYTE_W-1:0]   pick_byte;

   uart_rr_pick #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_pick (
      .req_i   (REQ),
      .ptr_i   (ptr_q),
      .valid_o (pick_valid),
      .win_o   (pick_id)
   );

   assign pick_byte = DATA_IN[32'(pick_id)*BYTE_W +: BYTE_W];

`ifdef UART_ARB_WDOG_EN
   localparam int unsigned WDOG_W = (WDOG_CYC > 1) ? $clog2(WDOG_CYC) : 1;

   logic [WDOG_W-1:0]   wdog_q, wdog_d;
   logic                err_q, err_d;
`endif

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      cur_id_d = cur_id_q;
      tx_din_d = tx_din_q;
      wr_en_d  = 1'b1;
      ack_d    = '0;
`ifdef UART_ARB_WDOG_EN
      wdog_d   = wdog_q;
      err_d    = 1'b0;
`endif
      case (state_q)
         ARB_IDLE: begin
            // A still-draining transmitter (e.g. after reset) blocks any grant.
            if (!TX_BUSY && pick_valid) begin
               tx_din_d = pick_byte;
               cur_id_d = pick_id;
               wr_en_d  = 1'b0;
               state_d  = ARB_LAUNCH;
            end
         end
         ARB_LAUNCH: begin
            state_d = ARB_WAIT_BUSY;
`ifdef UART_ARB_WDOG_EN
            wdog_d  = '0;
`endif
         end
         ARB_WAIT_BUSY: begin
            if (TX_BUSY) begin
               ack_d[cur_id_q] = 1'b1;
               ptr_d           = cur_id_q;
               state_d         = ARB_WAIT_DONE;
            end
`ifdef UART_ARB_WDOG_EN
            else if (wdog_q == WDOG_W'(WDOG_CYC - 1)) begin
               // Abandon the launch; the requester keeps REQ and waits its next turn.
               err_d   = 1'b1;
               ptr_d   = cur_id_q;
               state_d = ARB_IDLE;
            end else begin
               wdog_d = wdog_q + 1'b1;
            end
`endif
         end
         ARB_WAIT_DONE: begin
            if (!TX_BUSY) begin
               state_d = ARB_IDLE;
            end
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q  <= ARB_IDLE;
         ptr_q    <= IDW'(NREQ - 1);
         cur_id_q <= '0;
         tx_din_q <= '0;
         wr_en_q  <= 1'b1;
         ack_q    <= '0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         cur_id_q <= cur_id_d;
         tx_din_q <= tx_din_d;
         wr_en_q  <= wr_en_d;
         ack_q    <= ack_d;
      end
   end

`ifdef UART_ARB_WDOG_EN
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         wdog_q <= '0;
         err_q  <= 1'b0;
      end else begin
         wdog_q <= wdog_d;
         err_q  <= err_d;
      end
   end

   assign ERR = err_q;
`else
   assign ERR = 1'b0;
`endif

   assign ACK      = ack_q;
   assign CUR_ID   = cur_id_q;
   assign TX_DIN   = tx_din_q;
   assign TX_WR_EN = wr_en_q;
   assign ARB_BUSY = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter with a behavioural uartTx and round-robin model.
module tb_uart_tx_arbiter;

   localparam int unsigned NREQ = 4;
   localparam int unsigned IDW  = 2;

   typedef struct { int cyc; logic [NREQ-1:0] v; } ack_ev_t;
   typedef struct { int cyc; logic [7:0] din; }    wr_ev_t;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [NREQ-1:0]   req;
   logic [NREQ*8-1:0] data_in;
   logic [NREQ-1:0]   ack;
   logic [IDW-1:0]    cur_id;
   logic              arb_busy;
   logic [7:0]        tx_din;
   logic              tx_wr_en;
   logic              tx_busy = 1'b0;
   logic              err;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   uart_tx_arbiter #(
      .NREQ     (NREQ),
      .IDW      (IDW),
      .WDOG_CYC (8)
   ) dut (
      .CLK      (clk),
      .RST_N    (rst_n),
      .REQ      (req),
      .DATA_IN  (data_in),
      .ACK      (ack),
      .CUR_ID   (cur_id),
      .ARB_BUSY (arb_busy),
      .TX_DIN   (tx_din),
      .TX_WR_EN (tx_wr_en),
      .TX_BUSY  (tx_busy),
      .ERR      (err)
   );

   // Behavioural uartTx: starts a frame when idle and WR_EN is low, busy for 5..9 cycles.
   int         cyc = 0;
   int         tx_cnt = 0;
   int         launch_while_busy = 0;
   int         wr_run = 0;
   int         long_strobe = 0;
   int         err_cnt = 0;
   logic       busy_prev = 1'b0;
   logic [7:0] sent_q[$];
   ack_ev_t    ack_q[$];
   wr_ev_t     wr_q[$];
   int         fall_q[$];

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!tx_busy && tx_wr_en === 1'b0) begin
         tx_busy <= 1'b1;
         tx_cnt  <= $urandom_range(9, 5);
         sent_q.push_back(tx_din);
      end else if (tx_busy) begin
         if (tx_cnt == 1) tx_busy <= 1'b0;
         tx_cnt <= tx_cnt - 1;
      end
      if (tx_wr_en === 1'b0 && tx_busy) launch_while_busy <= launch_while_busy + 1;
      wr_run <= (tx_wr_en === 1'b0) ? wr_run + 1 : 0;
      if (tx_wr_en === 1'b0 && wr_run >= 1) long_strobe <= long_strobe + 1;
   end

   always @(negedge clk) begin
      if (ack != '0 && !$isunknown(ack)) ack_q.push_back('{cyc, ack});
      if (tx_wr_en === 1'b0) wr_q.push_back('{cyc, tx_din});
      if (busy_prev && !tx_busy) fall_q.push_back(cyc);
      if (err === 1'b1) err_cnt <= err_cnt + 1;
      busy_prev <= tx_busy;
   end

   // Reference: bytes per requester and the round-robin pointer derived from grants.
   logic [7:0]  bytes [NREQ];
   int unsigned mptr;

   function automatic int unsigned rr_next(input logic [NREQ-1:0] mask, input int unsigned p);
      for (int unsigned k = 1; k <= NREQ; k++) begin
         if (((mask >> ((p + k) % NREQ)) & 1) != 0) return (p + k) % NREQ;
      end
      return NREQ;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_data();
      for (int i = 0; i < NREQ; i++) data_in[8*i +: 8] = bytes[i];
   endtask

   task automatic rand_bytes();
      for (int i = 0; i < NREQ; i++) bytes[i] = 8'($urandom);
      set_data();
   endtask

   task automatic clear_evs();
      ack_q.delete(); wr_q.delete(); sent_q.delete(); fall_q.delete();
   endtask

   task automatic wait_ev(input bit use_wr, input int n, input int budget, input string tag);
      int b = 0;
      while (((use_wr ? wr_q.size() : ack_q.size()) < n) && b < budget) begin
         @(negedge clk); #1; b++;
      end
      chk({tag, "_wait"}, 32'((use_wr ? wr_q.size() : ack_q.size()) >= n), 1);
   endtask

   task automatic wait_idle(input int budget, input string tag);
      int b = 0;
      while ((arb_busy || tx_busy) && b < budget) begin
         @(negedge clk); #1; b++;
      end
      chk({tag, "_idle"}, {30'd0, arb_busy, tx_busy}, 0);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_wr_en"},  tx_wr_en, 1);
      chk({tag, "_din"},    tx_din,   0);
      chk({tag, "_ack"},    ack,      0);
      chk({tag, "_cur_id"}, cur_id,   0);
      chk({tag, "_busy"},   arb_busy, 0);
      chk({tag, "_err"},    err,      0);
   endtask

   // Holds mask until n grants, then releases and checks order, bytes and timing.
   task automatic run_batch(input logic [NREQ-1:0] mask, input int n, input string tag);
      int          m;
      int unsigned e;
      logic [NREQ-1:0] ev;
      clear_evs();
      req = mask;
      wait_ev(1'b0, n, 20 * n + 20, tag);
      req = '0;
      wait_idle(40, tag);
      chk({tag, "_nlaunch"}, wr_q.size(), n);
      chk({tag, "_nack"},    ack_q.size(), n);
      chk({tag, "_nsent"},   sent_q.size(), n);
      m = n;
      if (ack_q.size() < m) m = ack_q.size();
      if (wr_q.size() < m) m = wr_q.size();
      if (sent_q.size() < m) m = sent_q.size();
      for (int k = 0; k < m; k++) begin
         e  = rr_next(mask, mptr);
         ev = NREQ'(1) << e;
         chk($sformatf("%s_ack%0d", tag, k),  ack_q[k].v, ev);
         chk($sformatf("%s_din%0d", tag, k),  wr_q[k].din, bytes[e]);
         chk($sformatf("%s_sent%0d", tag, k), sent_q[k], bytes[e]);
         chk($sformatf("%s_lat%0d", tag, k),  ack_q[k].cyc - wr_q[k].cyc, 2);
         if (k > 0 && k - 1 < fall_q.size())
            chk($sformatf("%s_gap%0d", tag, k), wr_q[k].cyc - fall_q[k-1], 2);
         mptr = e;
      end
   endtask

   initial begin
      rst_n = 1'b1;
      req   = '0;
      for (int i = 0; i < NREQ; i++) bytes[i] = 8'h00;
      set_data();
      #1 rst_n = 1'b0;
      #1 chk_reset_vals("por");
      repeat (3) @(negedge clk);
      #1 rst_n = 1'b1;
      mptr = NREQ - 1;

      bytes[0] = 8'hA5; set_data();
      run_batch(4'b0001, 1, "single");

      rst_n = 1'b0;
      @(negedge clk); #1 rst_n = 1'b1;
      mptr = NREQ - 1;
      bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33; bytes[3] = 8'h44; set_data();
      run_batch(4'b1111, 5, "all");

      rand_bytes();
      run_batch(4'b0100, 4, "persist");

      // Requester 1 joins while requester 0's frame is in flight.
      rand_bytes();
      clear_evs();
      req = 4'b0001;
      wait_ev(1'b1, 1, 20, "mid_l");
      req = 4'b0011;
      wait_ev(1'b0, 1, 20, "mid_a0");
      req = 4'b0010;
      wait_ev(1'b0, 2, 40, "mid_a1");
      req = '0;
      wait_idle(40, "mid");
      chk("mid_nack", ack_q.size(), 2);
      if (ack_q.size() == 2 && wr_q.size() == 2 && sent_q.size() == 2 && fall_q.size() >= 1) begin
         mptr = rr_next(4'b0001, mptr);
         chk("mid_ack0", ack_q[0].v, NREQ'(1) << mptr);
         mptr = rr_next(4'b0010, mptr);
         chk("mid_ack1", ack_q[1].v, NREQ'(1) << mptr);
         chk("mid_sent1", sent_q[1], bytes[mptr]);
         chk("mid_gap", wr_q[1].cyc - fall_q[0], 2);
      end

      // Reset while the transmitter is still busy with a frame.
      rand_bytes();
      clear_evs();
      req = 4'b0001;
      wait_ev(1'b0, 1, 20, "rst_a");
      chk("rst_pre_busy", tx_busy, 1);
      rst_n = 1'b0;
      #1 chk_reset_vals("midrst");
      @(negedge clk); #1 rst_n = 1'b1;
      mptr = NREQ - 1;
      clear_evs();
      wait_ev(1'b0, 1, 40, "rst_b");
      req = '0;
      wait_idle(40, "rst");
      chk("rst_nlaunch", wr_q.size(), 1);
      if (ack_q.size() >= 1 && wr_q.size() >= 1 && sent_q.size() >= 1 && fall_q.size() >= 1) begin
         mptr = rr_next(4'b0001, mptr);
         chk("rst_ack", ack_q[0].v, NREQ'(1) << mptr);
         chk("rst_sent", sent_q[0], bytes[mptr]);
         chk("rst_gap", wr_q[0].cyc - fall_q[0], 1);
      end

      for (int r = 0; r < 6; r++) begin
         rand_bytes();
         run_batch(NREQ'($urandom_range(15, 1)), $urandom_range(6, 2), $sformatf("rnd%0d", r));
      end

      chk("no_launch_busy", launch_while_busy, 0);
      chk("strobe_1cyc",    long_strobe, 0);
      chk("err_quiet",      err_cnt, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
